usb_tx_bit_timer: RTL and testbench
===================================

# usb_tx_bit_timer

Parametrised transmit timing generator for the USB transmitter datapath. It generates per-bit strobes, per-byte load strobes, the current byte index and end-of-data for a packet whose length is set at run time. It also supports stalling for stuffed bits. It sits between the transmit controller FSM, which drives start, reset, enable and stuff requests, and the shift register and encoder, which consume new_bit and load_byte.

## Interface
- CLKS_PER_BIT, default 8: clock cycles per bit period; legal values ≥2.
- BITS_PER_BYTE, default 8: bits per byte; legal values ≥2.
- MAX_BYTES, default 64: maximum packet length in bytes; legal values ≥2.
- clk, input, 1: system clock; all state updates on the rising edge.
- n_rst, input, 1: asynchronous active-low reset.
- tim_rst, input, 1: synchronous clear; highest priority after n_rst.
- tim_en, input, 1: global count enable; when low, all counters and state freeze.
- start, input, 1: packet start request; accepted only in IDLE with tim_en=1.
- pkt_len, input, $clog2(MAX_BYTES+1): byte count, latched on start acceptance.
- stuff_req, input, 1: insert a stuffed bit after the bit ending this cycle; sampled only on new_bit cycles.
- new_bit, output, 1: one-cycle strobe that ends each bit period (data or stuffed).
- load_byte, output, 1: one-cycle strobe; the shift register loads byte byte_out.
- byte_out, output, $clog2(MAX_BYTES): index of the byte currently being transmitted.
- eod, output, 1: one-cycle strobe on the final bit boundary of the packet.
- busy, output, 1: high while state ≠ IDLE.

## Operation
- States:
  - IDLE, RUN and STUFF are held in a registered FSM.
  - Internal counters are width_cnt (0..CLKS_PER_BIT-1), bit_cnt (0..BITS_PER_BYTE-1), byte_cnt (drives byte_out) and len_q.
- Length latch:
  - On start acceptance, len_q = pkt_len.
  - pkt_len=0 or pkt_len>MAX_BYTES latches MAX_BYTES.
- Start:
  - IDLE → RUN; width_cnt, bit_cnt and byte_cnt are cleared.
  - load_byte is asserted in the first RUN cycle, for byte 0.
  - start while busy is ignored.
- Bit timing:
  - In RUN or STUFF with tim_en=1, width_cnt increments and wraps at CLKS_PER_BIT-1.
  - new_bit = (state≠IDLE) & tim_en & (width_cnt==CLKS_PER_BIT-1).
- Data bit end (new_bit in RUN, stuff_req=0):
  - If bit_cnt < BITS_PER_BYTE-1: bit_cnt increments.
  - Else, if byte_cnt < len_q-1: load_byte is asserted, bit_cnt clears and byte_cnt increments.
  - Else: eod is asserted and the FSM goes to IDLE.
- Stuffing (new_bit in RUN, stuff_req=1):
  - RUN → STUFF; bit_cnt and byte_cnt hold.
  - Any load_byte or eod due on this edge is deferred to the new_bit that ends the stuff period.
- Stuff period end:
  - new_bit in STUFF takes the data-bit-end action above, using the held counters.
  - stuff_req is ignored in STUFF, so there are no back-to-back stuffs.
- tim_rst:
  - Next state is IDLE and all counters are 0; combinational strobes are suppressed in that cycle.
  - start in the same cycle is ignored.
- tim_en=0: state and counters hold, and new_bit, load_byte and eod are 0.
- Reset value of all outputs and state: 0 / IDLE.

## Timing
- Let C=CLKS_PER_BIT, B=BITS_PER_BYTE and N=latched length. start is sampled at edge 0.
- Cycle 1: busy=1, load_byte=1, byte_out=0.
- new_bit fires in cycles k·C for k≥1.
- load_byte for byte j (j≥1) fires in cycle j·B·C.
- byte_out increments on the following edge.
- Without stuffing, eod fires in cycle N·B·C; busy=0 from cycle N·B·C+1.
- Each accepted stuff_req adds exactly C cycles to all later events.
- Each tim_en=0 cycle adds exactly 1 cycle to all later events.
- A new start is accepted the cycle busy returns low.

## Configuration
- USB_TX_BIT_TIMER_STUFF_EN defined:
  - The STUFF state and stuff_req handling are compiled in, as specified above.
- USB_TX_BIT_TIMER_STUFF_EN undefined:
  - The STUFF state is absent and stuff_req is an unused input.
  - Timing equals the no-stuffing case for all stimulus.

## Test plan
- Defaults, pkt_len=2, no stuffing:
  - load_byte in cycles 1 and 64.
  - new_bit in cycles 8,16,…,128.
  - eod in cycle 128; busy low in cycle 129.
- Macro on, pkt_len=2, stuff_req on the new_bit in cycle 24:
  - No bit advance at cycle 32.
  - load_byte in cycle 72, eod in cycle 136.
  - A stuff on the last bit (cycle 128) moves eod to 136.
- pkt_len=2, tim_en low for cycles 30–34:
  - Strobes are suppressed in those cycles.
  - load_byte moves to cycle 69, eod to cycle 133.
- tim_rst in cycle 50 of a packet:
  - busy=0 and byte_out=0 from cycle 51.
  - A subsequent start gives load_byte one cycle later.
- pkt_len=0 → eod in cycle 4096 with byte_out=63 before it; pkt_len=100 → same result.
- Macro off, stimulus as in the stuffing test: stuff_req is ignored, eod in cycle 128.

Source files
------------

// File: rtl/usb_tx_bit_timer.sv
// USB TX bit/byte timing generator; STUFF state compiled in with USB_TX_BIT_TIMER_STUFF_EN.
// Strobes are combinational off registered counters; tim_en=0 freezes all state and gates all strobes.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8,
  parameter int MAX_BYTES     = 64
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 tim_rst,
  input  logic                                 tim_en,
  input  logic                                 start,
  input  logic [$clog2(MAX_BYTES+1)-1:0]       pkt_len,
  input  logic                                 stuff_req,
  output logic                                 new_bit,
  output logic                                 load_byte,
  output logic [$clog2(MAX_BYTES)-1:0]         byte_out,
  output logic                                 eod,
  output logic                                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int YW = $clog2(MAX_BYTES);

`ifdef USB_TX_BIT_TIMER_STUFF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STUFF = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
  logic unused_stuff_req;
  assign unused_stuff_req = stuff_req;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   width_q, width_d;
  logic [BW-1:0]   bit_q,   bit_d;
  logic [YW-1:0]   byte_q,  byte_d;
  logic [LW-1:0]   len_q,   len_d;

  logic            wrap;
  logic            bit_last;
  logic            byte_last;
  logic            advance;
  logic [LW-1:0]   len_latch;

  assign wrap      = (width_q == CW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BW'(BITS_PER_BYTE - 1));
  assign byte_last = !(LW'(byte_q) < (len_q - LW'(1)));

  // Out-of-range lengths (including 0) run a maximum-size packet.
  assign len_latch = ((pkt_len == '0) || (pkt_len > LW'(MAX_BYTES))) ? LW'(MAX_BYTES) : pkt_len;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      width_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    len_d     = len_q;
    new_bit   = 1'b0;
    load_byte = 1'b0;
    eod       = 1'b0;
    advance   = 1'b0;

    if (tim_rst) begin
      state_d = IDLE;
      width_d = '0;
      bit_d   = '0;
      byte_d  = '0;
      len_d   = '0;
    end else if (tim_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            width_d = '0;
            bit_d   = '0;
            byte_d  = '0;
            len_d   = len_latch;
          end
        end
        RUN: begin
          new_bit = wrap;
          width_d = wrap ? '0 : width_q + CW'(1);
          // All-zero counters in RUN only occur in the first active cycle of a packet.
          if (width_q == '0 && bit_q == '0 && byte_q == '0)
            load_byte = 1'b1;
          if (wrap) begin
`ifdef USB_TX_BIT_TIMER_STUFF_EN
            if (stuff_req)
              state_d = STUFF;
            else
              advance = 1'b1;
`else
            advance = 1'b1;
`endif
          end
        end
`ifdef USB_TX_BIT_TIMER_STUFF_EN
        STUFF: begin
          new_bit = wrap;
          width_d = wrap ? '0 : width_q + CW'(1);
          if (wrap) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          width_d = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      endcase

      // Deferred stuff-period ends reuse the held counters here.
      if (advance) begin
        if (!bit_last) begin
          bit_d = bit_q + BW'(1);
        end else if (!byte_last) begin
          load_byte = 1'b1;
          bit_d     = '0;
          byte_d    = byte_q + YW'(1);
        end else begin
          eod     = 1'b1;
          state_d = IDLE;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign byte_out = byte_q;

endmodule

// File: tb/tb_usb_tx_bit_timer.sv
// Bench for usb_tx_bit_timer: directed timing scenarios plus random traffic against a cycle-count reference model.
module tb_usb_tx_bit_timer;

  localparam int C  = 8;
  localparam int B  = 8;
  localparam int M  = 64;
  localparam int LW = $clog2(M + 1);
  localparam int YW = $clog2(M);
`ifdef USB_TX_BIT_TIMER_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          tim_rst;
  logic          tim_en;
  logic          start;
  logic [LW-1:0] pkt_len;
  logic          stuff_req;
  logic          new_bit;
  logic          load_byte;
  logic [YW-1:0] byte_out;
  logic          eod;
  logic          busy;

  always #5 clk = ~clk;

  usb_tx_bit_timer #(.CLKS_PER_BIT(C), .BITS_PER_BYTE(B), .MAX_BYTES(M)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tim_rst   (tim_rst),
    .tim_en    (tim_en),
    .start     (start),
    .pkt_len   (pkt_len),
    .stuff_req (stuff_req),
    .new_bit   (new_bit),
    .load_byte (load_byte),
    .byte_out  (byte_out),
    .eod       (eod),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: enabled-cycle count since start; data bits done = periods ended - stuffs.
  bit m_busy     = 1'b0;
  bit m_first    = 1'b0;
  bit m_in_stuff = 1'b0;
  int m_t        = 0;
  int m_nstuff   = 0;
  int m_len      = 0;
  int m_done     = 0;

  int load_cyc[$];
  int eod_cyc     = -1;
  int byte_at_eod = -1;
  int nb_cnt      = 0;
  int first_nb    = -1;
  logic [31:0] obs_busy;
  logic [31:0] obs_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    logic [31:0] e_nb, e_ld, e_eod, e_busy, e_byte;
    bit nxt_busy;
    bit stuffing;
    int d;
    @(negedge clk);
    e_nb = 0; e_ld = 0; e_eod = 0;
    e_busy = 32'(m_busy);
    e_byte = 32'(m_done / B);
    nxt_busy = m_busy;
    if (tim_rst) begin
      nxt_busy = 1'b0;
      m_done   = 0;
    end else if (m_busy && tim_en) begin
      e_ld    = 32'(m_first);
      m_first = 1'b0;
      if (m_t % C == C - 1) begin
        e_nb = 1;
        stuffing = STUFF_ON && stuff_req && !m_in_stuff;
        if (stuffing) begin
          m_nstuff++;
          m_in_stuff = 1'b1;
        end else begin
          m_in_stuff = 1'b0;
          d = (m_t + 1) / C - m_nstuff;
          m_done = d;
          if (d % B == 0) begin
            if (d / B < m_len) e_ld = 1;
            else begin
              e_eod = 1;
              nxt_busy = 1'b0;
            end
          end
        end
      end
      m_t++;
    end else if (!m_busy && tim_en && start) begin
      nxt_busy   = 1'b1;
      m_len      = (pkt_len == 0 || int'(pkt_len) > M) ? M : int'(pkt_len);
      m_t        = 0;
      m_nstuff   = 0;
      m_in_stuff = 1'b0;
      m_first    = 1'b1;
      m_done     = 0;
    end
    check("new_bit",   32'(new_bit),   e_nb);
    check("load_byte", 32'(load_byte), e_ld);
    check("eod",       32'(eod),       e_eod);
    check("busy",      32'(busy),      e_busy);
    if (e_busy == 1) check("byte_out", 32'(byte_out), e_byte);
    m_busy = nxt_busy;
    if (new_bit) begin
      nb_cnt++;
      if (first_nb < 0) first_nb = cyc;
    end
    if (load_byte) load_cyc.push_back(cyc);
    if (eod) begin
      eod_cyc     = cyc;
      byte_at_eod = int'(byte_out);
    end
    obs_busy = 32'(busy);
    obs_byte = 32'(byte_out);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    start = 1'b0; tim_rst = 1'b0; tim_en = 1'b1; stuff_req = 1'b0;
  endtask

  // One packet starting in cycle 0; -1 disables an optional event.
  task automatic run_pkt(input int len, input int st_a, input int st_b,
                         input int en_a, input int en_b, input int rst_at, input int limit);
    load_cyc.delete();
    eod_cyc = -1; byte_at_eod = -1; nb_cnt = 0; first_nb = -1;
    cyc = 0;
    pkt_len = LW'(len);
    do begin
      start     = (cyc == 0);
      stuff_req = (cyc == st_a) || (cyc == st_b);
      tim_en    = !(cyc >= en_a && cyc <= en_b);
      tim_rst   = (cyc == rst_at);
      step();
    end while (m_busy && cyc < limit);
    idle_inputs();
    step();
    check("pkt_done_busy", obs_busy, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    pkt_len = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_byte", 32'(byte_out), 0);
    check("rst_new_bit", 32'(new_bit), 0);
    check("rst_load", 32'(load_byte), 0);
    check("rst_eod", 32'(eod), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step();

    run_pkt(2, -1, -1, -1, -1, -1, 400);
    check("plain_nloads", load_cyc.size(), 2);
    check("plain_load0", load_cyc[0], 1);
    check("plain_load1", load_cyc[1], 64);
    check("plain_first_nb", first_nb, 8);
    check("plain_nb_cnt", nb_cnt, 16);
    check("plain_eod", eod_cyc, 128);
    check("plain_byte_eod", byte_at_eod, 1);

    run_pkt(2, 24, -1, -1, -1, -1, 400);
    check("stuff24_load1", load_cyc[1], STUFF_ON ? 72 : 64);
    check("stuff24_eod", eod_cyc, STUFF_ON ? 136 : 128);
    check("stuff24_nb_cnt", nb_cnt, STUFF_ON ? 17 : 16);

    run_pkt(2, 128, -1, -1, -1, -1, 400);
    check("stufflast_load1", load_cyc[1], 64);
    check("stufflast_eod", eod_cyc, STUFF_ON ? 136 : 128);

    run_pkt(2, -1, -1, 30, 34, -1, 400);
    check("en_lo_load1", load_cyc[1], 69);
    check("en_lo_eod", eod_cyc, 133);

    run_pkt(2, -1, -1, -1, -1, 50, 400);
    check("trst_busy", obs_busy, 0);
    check("trst_byte", obs_byte, 0);
    check("trst_no_eod", eod_cyc, -1);
    run_pkt(1, -1, -1, -1, -1, -1, 400);
    check("trst_restart_load", load_cyc[0], 1);
    check("len1_eod", eod_cyc, 64);

    run_pkt(0, -1, -1, -1, -1, -1, 5000);
    check("len0_eod", eod_cyc, 4096);
    check("len0_byte", byte_at_eod, 63);
    run_pkt(100, -1, -1, -1, -1, -1, 5000);
    check("len100_eod", eod_cyc, 4096);
    check("len100_byte", byte_at_eod, 63);

    // Random traffic: start attempts while busy, enable gaps, stuff requests, rare clears.
    for (int i = 0; i < 6000; i++) begin
      start     = ($urandom % 6) == 0;
      pkt_len   = LW'($urandom_range(1, 3));
      tim_en    = ($urandom % 10) != 0;
      stuff_req = ($urandom % 4) == 0;
      tim_rst   = ($urandom % 400) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
